// File: rtl/pedestrian_signal.sv
// Pedestrian Walk/DontWalk controller slaved to traffic_light lamp outputs.
// Optional audible cue enabled by defining PED_CHIRP_EN.
module pedestrian_signal #(
    parameter int WALK_CYCLES  = 12,
    parameter int CLEAR_CYCLES = 10,
    parameter int FLASH_HALF   = 2,
    parameter int CHIRP_PERIOD = 4,
    parameter int CW           = 5
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Red,
    input  logic          Yellow,
    input  logic          Green,
    input  logic          Button,
    output logic          Walk,
    output logic          DontWalk,
    output logic [CW-1:0] Countdown,
    output logic          RequestPending,
    output logic          Fault,
    output logic          Chirp
);

    localparam int WW = (WALK_CYCLES > 1) ? $clog2(WALK_CYCLES) : 1;
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    if (WALK_CYCLES < 1 || CLEAR_CYCLES < 1 || CLEAR_CYCLES > 2**CW - 1 ||
        FLASH_HALF < 1 || CHIRP_PERIOD < 1) begin : g_bad_param
        $error("pedestrian_signal: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, WALK, CLEAR, HOLD, FAULT} state_t;

    state_t          state, n_state;
    logic            red_prev;
    logic [WW-1:0]   walk_cnt, n_walk;
    logic [FW-1:0]   flash_cnt, n_flash;
    logic [CW-1:0]   n_cd;
    logic            n_dw, n_rp;
    logic            red_entry, conflict;

    assign red_entry = Red & ~red_prev;
    assign conflict  = (Red & Yellow) | (Red & Green) | (Yellow & Green);

    always_comb begin
        n_state = state;
        n_walk  = walk_cnt;
        n_flash = '0;
        n_cd    = '0;
        n_dw    = 1'b1;
        n_rp    = RequestPending;

        case (state)
            IDLE: begin
                if (red_entry && (RequestPending || Button)) begin
                    n_state = WALK;
                    n_walk  = '0;
                end
            end
            WALK: begin
                if (!Red) begin
                    n_state = IDLE;
                end else if (walk_cnt == WW'(WALK_CYCLES - 1)) begin
                    n_state = CLEAR;
                    n_cd    = CW'(CLEAR_CYCLES);
                end else begin
                    n_walk = walk_cnt + WW'(1);
                end
            end
            CLEAR: begin
                if (!Red) begin
                    n_state = IDLE;
                end else if (Countdown <= CW'(1)) begin
                    n_state = HOLD;
                end else begin
                    // Countdown doubles as the clearance timer; DontWalk holds the flash phase.
                    n_cd = Countdown - CW'(1);
                    if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                        n_flash = '0;
                        n_dw    = ~DontWalk;
                    end else begin
                        n_flash = flash_cnt + FW'(1);
                        n_dw    = DontWalk;
                    end
                end
            end
            HOLD: begin
                if (!Red)
                    n_state = IDLE;
            end
            default: ;
        endcase

        if (conflict)
            n_state = FAULT;

        // Requests are ignored while walking and frozen once faulted.
        if (state != WALK && state != FAULT)
            n_rp = (n_state == WALK) ? 1'b0 : (RequestPending | Button);

        if (n_state != CLEAR) begin
            n_cd = '0;
            n_dw = (n_state != WALK);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            red_prev       <= 1'b1;
            walk_cnt       <= '0;
            flash_cnt      <= '0;
            Walk           <= 1'b0;
            DontWalk       <= 1'b1;
            Countdown      <= '0;
            RequestPending <= 1'b0;
            Fault          <= 1'b0;
        end else begin
            state          <= n_state;
            red_prev       <= Red;
            walk_cnt       <= n_walk;
            flash_cnt      <= n_flash;
            Walk           <= (n_state == WALK);
            DontWalk       <= n_dw;
            Countdown      <= n_cd;
            RequestPending <= n_rp;
            Fault          <= (n_state == FAULT);
        end
    end

`ifdef PED_CHIRP_EN
    localparam int PW = (CHIRP_PERIOD > 1) ? $clog2(CHIRP_PERIOD) : 1;
    logic [PW-1:0] chirp_cnt, n_chirp;

    always_comb begin
        n_chirp = '0;
        if (state == WALK && n_state == WALK)
            n_chirp = (chirp_cnt == PW'(CHIRP_PERIOD - 1)) ? '0 : chirp_cnt + PW'(1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            chirp_cnt <= '0;
            Chirp     <= 1'b0;
        end else begin
            chirp_cnt <= n_chirp;
            Chirp     <= (n_state == WALK) && (n_chirp == '0);
        end
    end
`else
    assign Chirp = 1'b0;
`endif

endmodule
